// File: rtl/delay_counter.sv
// -----------------------------------------------------------------------------
// delay_counter
//   One-shot delay timer used by the ST7735 LCD init sequencer for the panel
//   reset pulse and the long power-up waits. While start is held high the
//   block counts system clocks. Once N = CLOCK_SPEED_MHZ*US_DELAY cycles have
//   elapsed (N is at least 1), out goes high and stays high. Dropping start
//   clears the timer so that it is ready for the next wait.
//
// Ports
//   CLK    in  1  system clock, rising edge
//   RESET  in  1  synchronous, active-high reset (has priority over start)
//   start  in  1  level enable: high = run/hold, low = clear
//   out    out 1  registered done flag
// -----------------------------------------------------------------------------
module delay_counter #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int US_DELAY        = 120000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  output logic out
);

  // A zero-length delay still takes one start-high edge.
  localparam int N_RAW = CLOCK_SPEED_MHZ * US_DELAY;
  localparam int N     = (N_RAW < 1) ? 1 : N_RAW;
  localparam int W_RAW = $clog2(N + 1);
  localparam int W     = (W_RAW < 1) ? 1 : W_RAW;

  // Terminal count: the edge that sees cnt at this value raises out.
  localparam logic [W-1:0] CNT_LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // Three behaviours share one register block:
  //   idle  (start low or reset)  -> everything cleared
  //   count (start high, out low) -> advance until the terminal count
  //   done  (start high, out high)-> hold; no wrap, no retrigger
  always_ff @(posedge CLK) begin
    if (RESET || !start) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (!out) begin
      if (cnt == CNT_LAST) begin
        out <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_counter.sv
// -----------------------------------------------------------------------------
// tb_delay_counter
//   Drives two timers from the same RESET/start stimulus: one with N=5
//   (1 MHz, 5 us) and one with the zero-delay case (N forced to 1).
//   For every driven edge the bench computes the expected state from the
//   length of the current unbroken run of start-high edges and queues it;
//   after the edge the entry is popped and compared with the DUTs.
// -----------------------------------------------------------------------------
module tb_delay_counter;

  localparam int N_A = 5;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic start = 1'b0;
  logic out_a;
  logic out_b;

  always #5 CLK = ~CLK;

  delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(5)) dut_a (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .out   (out_a)
  );

  delay_counter #(.CLOCK_SPEED_MHZ(1), .US_DELAY(0)) dut_b (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .out   (out_b)
  );

  typedef struct {
    string tag;
    logic  out_a;
    int    cnt_a;
    logic  out_b;
    int    cnt_b;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int run_len  = 0;   // consecutive start-high edges since last clear

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive one edge worth of inputs, queue the expectation, then compare
  // after the edge.
  task automatic step(input string tag, input logic rst, input logic st);
    exp_t e;
    exp_t got;
    @(negedge CLK);
    RESET = rst;
    start = st;
    if (rst || !st) run_len = 0;
    else            run_len++;
    e.tag   = tag;
    e.out_a = (run_len >= N_A);
    e.cnt_a = (run_len < N_A) ? run_len : N_A - 1;
    e.out_b = (run_len >= 1);
    e.cnt_b = 0;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    got = exp_q.pop_front();
    check_val({got.tag, "/out_n5"}, int'(out_a), int'(got.out_a));
    check_val({got.tag, "/cnt_n5"}, int'(dut_a.cnt), got.cnt_a);
    check_val({got.tag, "/out_n1"}, int'(out_b), int'(got.out_b));
    check_val({got.tag, "/cnt_n1"}, int'(dut_b.cnt), got.cnt_b);
  endtask

  task automatic hold(input string tag, input logic rst, input logic st, input int n);
    for (int i = 0; i < n; i++) step(tag, rst, st);
  endtask

  initial begin
    // 1: reset held with start high, then release
    hold("reset", 1'b1, 1'b1, 2);
    hold("post_reset", 1'b0, 1'b1, 6);
    step("clear1", 1'b0, 1'b0);

    // 2: fresh run, then long hold in done
    hold("run", 1'b0, 1'b1, 5);
    hold("done_hold", 1'b0, 1'b1, 20);

    // 4: reuse after completion with one low cycle
    step("reuse_drop", 1'b0, 1'b0);
    hold("reuse_run", 1'b0, 1'b1, 6);
    step("clear2", 1'b0, 1'b0);

    // 3: abort mid-count, then full restart
    hold("abort_pre", 1'b0, 1'b1, 3);
    step("abort_low", 1'b0, 1'b0);
    hold("abort_rerun", 1'b0, 1'b1, 7);

    // 6: reset while done and start high
    step("reset_done", 1'b1, 1'b1);
    hold("reset_rerun", 1'b0, 1'b1, 6);

    // random start pattern with occasional reset
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0));
    end

    if (exp_q.size() != 0) check_val("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
